// File: rtl/dmem_bridge_if.sv
// -----------------------------------------------------------------------------
// dmem_bridge_if
//
// Purpose:
//   Variable-latency memory bus carrying one req/ack transaction at a time.
//   The bridge is the master and the memory is the slave.
//
// Signals:
//   bus_req    master -> slave  request, held until bus_ack is seen
//   bus_we     master -> slave  1 = write, 0 = read; valid while bus_req is high
//   bus_addr   master -> slave  word-aligned byte address; valid while bus_req is high
//   bus_wdata  master -> slave  write data; valid while bus_req is high
//   bus_ack    slave -> master  one-cycle completion strobe
//   bus_rdata  slave -> master  read data; meaningful only while bus_ack is high
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface dmem_bridge_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_ack,
    output bus_rdata
  );
endinterface : dmem_bridge_if

// File: rtl/dmem_bridge.sv
// -----------------------------------------------------------------------------
// dmem_bridge
//
// Purpose:
//   Sits between a single-cycle core's data port and a variable-latency
//   req/ack memory bus. Each load or store becomes one bus transaction while
//   the core is frozen by stall. Misaligned accesses never reach the bus, and
//   accesses the bus never acknowledges are aborted after TIMEOUT cycles.
//
// Parameters:
//   TIMEOUT   REQ cycles without bus_ack before an abort (legal range 1..255)
//   ERR_DATA  value returned on data_out after an aborted or misaligned load
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous reset, active low
//   data_addr  byte address from the core
//   data_in    store data from the core
//   mem_read   load request from the core
//   mem_write  store request from the core (wins over mem_read)
//   data_out   load data back to the core's writeback mux
//   stall      freezes PC and register write while high
//   misalign   one-cycle pulse (in DONE) for an access with data_addr[1:0] != 0
//   timeout    one-cycle pulse (in DONE) for an access aborted without ack
//   bus        memory bus, master side
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module dmem_bridge #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [31:0]    data_addr,
  input  logic [31:0]    data_in,
  input  logic           mem_read,
  input  logic           mem_write,
  output logic [31:0]    data_out,
  output logic           stall,
  output logic           misalign,
  output logic           timeout,
  dmem_bridge_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Last REQ cycle (counter value) at which an ack is still accepted.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q,    we_d;
  logic [31:0] dout_q,  dout_d;
  logic        misal_q, misal_d;
  logic        tmo_q,   tmo_d;
  logic [7:0]  cnt_q,   cnt_d;

  logic        access;
  logic        aligned;

  assign access  = mem_read | mem_write;
  assign aligned = (data_addr[1:0] == 2'b00);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every register here, datapath included, is cleared by reset because
  // bus_addr, bus_wdata and data_out must read 0 straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      dout_q  <= '0;
      misal_q <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // of the previous cycle regardless of statement order.
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      dout_q  <= dout_d;
      misal_q <= misal_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every target gets a default first, so no path through the case
    // below can leave one unassigned and infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    // Status flags are registered pulses: they are set only on the edge into
    // DONE and therefore fall again on the edge leaving it.
    misal_d = 1'b0;
    tmo_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (access) begin
          addr_d  = {data_addr[31:2], 2'b00};
          wdata_d = data_in;
          we_d    = mem_write;
          if (aligned) begin
            state_d = S_REQ;
          end else begin
            // Misaligned: skip the bus entirely and report in DONE.
            state_d = S_DONE;
            misal_d = 1'b1;
            if (!mem_write) dout_d = ERR_DATA;
          end
        end
      end

      S_REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (bus.bus_ack) begin
          // An ack in the last allowed cycle still wins over the abort.
          if (!we_q) dout_d = bus.bus_rdata;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          tmo_d   = 1'b1;
          if (!we_q) dout_d = ERR_DATA;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // The core commits on this edge; any request still visible belongs
        // to the instruction that is completing, so it is not accepted here.
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // bus_req and stall decode the state register directly, so an asserted
  // reset takes them low at once. stall is also gated by reset so a request
  // held by the core during reset cannot raise it.
  assign bus.bus_req   = (state_q == S_REQ);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;

  assign stall    = reset & (((state_q == S_IDLE) & access) | (state_q == S_REQ));
  assign data_out = dout_q;
  assign misalign = misal_q;
  assign timeout  = tmo_q;

endmodule : dmem_bridge

// File: tb/tb_dmem_bridge.sv
// -----------------------------------------------------------------------------
// tb_dmem_bridge
//
// Drives the bridge like a core plus a memory that acknowledges after a
// chosen number of REQ cycles. Each access's expected outcome is predicted
// from the access rules and queued; an independent monitor measures each
// completed access (stall length, bus_req length, bus fields, pulses and
// data_out) and compares it against the head of the queue.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_dmem_bridge;

  localparam int          TMO = 4;
  localparam logic [31:0] ERR = 32'hDEAD_0BAD;

  typedef struct {
    logic        is_wr;
    logic        misal;
    logic        tmo;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          req_cycles;
    int          stall_cycles;
    logic [31:0] dout;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_addr, data_in, data_out;
  logic        mem_read, mem_write;
  logic        stall, misalign, timeout;

  dmem_bridge_if bus_if ();

  dmem_bridge #(.TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_addr (data_addr),
    .data_in   (data_in),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .data_out  (data_out),
    .stall     (stall),
    .misalign  (misalign),
    .timeout   (timeout),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  logic [31:0] model_dout = '0;
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  // Reference model: outcome of one access from the access rules alone.
  task automatic predict(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input int delay,
                         input logic [31:0] rdata, output exp_t e);
    logic is_load;
    is_load      = rd & ~wr;
    e.is_wr      = wr;
    e.addr       = {addr[31:2], 2'b00};
    e.wdata      = wd;
    e.misal      = 1'b0;
    e.tmo        = 1'b0;
    if (addr[1:0] != 2'b00) begin
      e.misal        = 1'b1;
      e.req_cycles   = 0;
      e.stall_cycles = 1;
      if (is_load) model_dout = ERR;
    end else if (delay < TMO) begin
      e.req_cycles   = delay + 1;
      e.stall_cycles = delay + 2;
      if (is_load) model_dout = rdata;
    end else begin
      e.tmo          = 1'b1;
      e.req_cycles   = TMO;
      e.stall_cycles = TMO + 1;
      if (is_load) model_dout = ERR;
    end
    e.dout = model_dout;
  endtask

  // One access: present it in IDLE, act as memory acking in REQ cycle
  // delay+1 (never if delay >= TMO), keep the request up through DONE,
  // and return one cycle later with the core lines dropped.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input int delay, input logic [31:0] rdata);
    exp_t e;
    int   n;
    bit   done;
    predict(rd, wr, addr, wd, delay, rdata, e);
    exp_q.push_back(e);
    mem_read  = rd;
    mem_write = wr;
    data_addr = addr;
    data_in   = wd;
    n    = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(posedge clk); #1;
      bus_if.bus_ack   = 1'b0;
      bus_if.bus_rdata = $urandom;
      if (!stall) begin
        done = 1'b1;
      end else if (bus_if.bus_req) begin
        n++;
        if (n == delay + 1) begin
          bus_if.bus_ack   = 1'b1;
          bus_if.bus_rdata = rdata;
        end
      end
    end
    check("access_completes", 32'(done), 32'd1);
    @(posedge clk); #1;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    bus_if.bus_ack = 1'b0;
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin : monitor
    bit          in_txn;
    bit          stable;
    int          st_cnt, rq_cnt;
    logic        f_we;
    logic [31:0] f_addr, f_wdata;
    exp_t        e;
    in_txn = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset || !mon_en) begin
        in_txn = 1'b0;
      end else if (stall) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          st_cnt = 0;
          rq_cnt = 0;
          stable = 1'b1;
        end
        st_cnt++;
        if (bus_if.bus_req) begin
          rq_cnt++;
          if (rq_cnt == 1) begin
            f_we    = bus_if.bus_we;
            f_addr  = bus_if.bus_addr;
            f_wdata = bus_if.bus_wdata;
          end else if (bus_if.bus_we !== f_we || bus_if.bus_addr !== f_addr ||
                       bus_if.bus_wdata !== f_wdata) begin
            stable = 1'b0;
          end
        end
      end else if (in_txn) begin
        in_txn = 1'b0;
        check("expected_access_queued", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("stall_cycles",   32'(st_cnt),          32'(e.stall_cycles));
          check("bus_req_cycles", 32'(rq_cnt),          32'(e.req_cycles));
          check("done_bus_req",   32'(bus_if.bus_req),  32'd0);
          check("misalign",       32'(misalign),        32'(e.misal));
          check("timeout",        32'(timeout),         32'(e.tmo));
          check("data_out",       data_out,             e.dout);
          if (e.req_cycles > 0) begin
            check("bus_we",     32'(f_we),   32'(e.is_wr));
            check("bus_addr",   f_addr,      e.addr);
            check("bus_stable", 32'(stable), 32'd1);
            if (e.is_wr) check("bus_wdata", f_wdata, e.wdata);
          end
        end
      end else begin
        check("idle_quiet", 32'({bus_if.bus_req, misalign, timeout}), 32'd0);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          kind, delay, gap;
    logic [31:0] addr;
    reset            = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    data_addr        = '0;
    data_in          = '0;
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = '0;
    #1;
    check("rst_bus_req",   32'(bus_if.bus_req), 32'd0);
    check("rst_bus_we",    32'(bus_if.bus_we),  32'd0);
    check("rst_stall",     32'(stall),          32'd0);
    check("rst_misalign",  32'(misalign),       32'd0);
    check("rst_timeout",   32'(timeout),        32'd0);
    check("rst_bus_addr",  bus_if.bus_addr,     32'd0);
    check("rst_bus_wdata", bus_if.bus_wdata,    32'd0);
    check("rst_data_out",  data_out,            32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Directed cases from the access rules.
    do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0,         0, 32'hCAFE_0001); // ack in first REQ cycle
    do_access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 3, 32'h0);         // store, ack 3 cycles late
    do_access(1'b1, 1'b0, 32'h0000_0006, 32'h0,         0, 32'h0);         // misaligned load
    do_access(1'b1, 1'b0, 32'h0000_0040, 32'h0,        99, 32'h0);         // timeout

    // Late ack after the abort must change nothing.
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    bus_if.bus_ack = 1'b0;
    check("late_ack_data_out", data_out,              model_dout);
    check("late_ack_state",    32'({bus_if.bus_req, stall}), 32'd0);

    do_access(1'b1, 1'b1, 32'h0000_0030, 32'hA5A5_0F0F, 1, 32'h7777_7777); // write wins
    do_access(1'b1, 1'b0, 32'h0000_0044, 32'h0, TMO - 1, 32'hBEEF_0004);   // ack in last cycle

    // Reset in the second REQ cycle of a load.
    mon_en    = 1'b0;
    mem_read  = 1'b1;
    data_addr = 32'h0000_0050;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_bus_req", 32'(bus_if.bus_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_reset_bus_req", 32'(bus_if.bus_req), 32'd0);
    check("mid_reset_stall",   32'(stall),          32'd0);
    @(posedge clk); #1;
    mem_read = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    model_dout = '0;
    check("post_reset_data_out", data_out, 32'd0);
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    bus_if.bus_ack = 1'b0;
    check("post_reset_ack_ignored", 32'({bus_if.bus_req, stall}), 32'd0);
    check("post_reset_ack_data",    data_out, 32'd0);
    mon_en = 1'b1;
    do_access(1'b1, 1'b0, 32'h0000_0050, 32'h0, 2, 32'h0F0F_1234);

    // Randomised traffic.
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 2);
      addr = $urandom;
      if ($urandom_range(0, 5) != 0) addr[1:0] = 2'b00;
      else if (addr[1:0] == 2'b00) addr[0] = 1'b1;
      delay = $urandom_range(0, TMO + 1);
      do_access(kind != 1, kind != 0, addr, $urandom, delay, $urandom);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_dmem_bridge
